// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end constants: instruction width, NOP encoding, major opcodes and the
// fetch queue entry layout.
package riscv_pkg;

   localparam int unsigned Ilen = 32;

   typedef logic [Ilen-1:0] insn_t;

   // addi x0, x0, 0
   localparam insn_t NopInsn = 32'h0000_0013;

   localparam logic [6:0] OpcLw    = 7'b0000011;
   localparam logic [6:0] OpcSw    = 7'b0100011;
   localparam logic [6:0] OpcBeq   = 7'b1100011;
   localparam logic [6:0] OpcAluop = 7'b0110011;

   typedef struct packed {
      insn_t       ir;
      logic [31:0] pc;
   } fetch_ent_t;

   function automatic logic is_nop(insn_t insn);
      return insn == NopInsn;
   endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Circular FIFO with an extra pointer bit for full/empty, synchronous flush and
// push-while-full allowed when a pop happens in the same cycle.
module riscv_fetch_fifo #(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned WIDTH  = 32,
   localparam int unsigned PtrW  = $clog2(QDEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PtrW:0]    count_o
);

   localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [QDEPTH];
   logic [PtrW:0]    wptr_q, wptr_d;
   logic [PtrW:0]    rptr_q, rptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                    (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
   assign count_o = wptr_q - rptr_q;
   assign rdata_o = mem_q[rptr_q[PtrW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + PtrOne;
         if (do_pop)  rptr_d = rptr_q + PtrOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wptr_q[PtrW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/riscv_ifetch_queue.sv
// Instruction fetch stage with credit-limited prefetch queue and redirect drop counting.
// Define FETCH_BYPASS_EN to forward a response straight into IF/ID when the queue is empty.
module riscv_ifetch_queue
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic [31:0] ifid_ir,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid
);

   localparam int unsigned CntW = $clog2(QDEPTH) + 1;

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
   logic [31:0]     ir_q, ir_d;
   logic [31:0]     pc_q, pc_d;
   logic            valid_q, valid_d;

   fetch_ent_t      q_wdata, q_rdata;
   logic            q_push, q_pop, q_full, q_empty;
   logic [CntW-1:0] q_count;

   logic [31:0]     a_rdata;
   logic            a_full, a_empty;
   logic [CntW-1:0] outstanding;

   logic [CntW:0]   in_flight;
   logic            credit_ok, req_fire;
   logic            rsp_eff, rsp_drop, rsp_take, bypass_take;

   // Every issued request reserves a queue slot until it is consumed or dropped.
   assign in_flight = {1'b0, q_count} + {1'b0, outstanding};
   assign credit_ok = in_flight < (CntW+1)'(QDEPTH);

   assign imem_req_valid = !reset && !redirect && credit_ok && !a_full;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // With nothing outstanding a response is a leftover from before reset.
   assign rsp_eff  = imem_rsp_valid && !a_empty && !reset;
   assign rsp_drop = rsp_eff && (redirect || (drop_cnt_q != '0));
   assign rsp_take = rsp_eff && !rsp_drop;

   assign q_pop = !stall && !redirect && !q_empty;

`ifdef FETCH_BYPASS_EN
   assign bypass_take = rsp_take && q_empty && !stall && !redirect;
`else
   assign bypass_take = 1'b0;
`endif

   assign q_push  = rsp_take && !bypass_take && (!q_full || q_pop);
   assign q_wdata = '{ir: imem_rsp_data, pc: a_rdata};

   riscv_fetch_fifo #(
      .QDEPTH (QDEPTH),
      .WIDTH  ($bits(fetch_ent_t))
   ) u_queue (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (redirect),
      .push_i  (q_push),
      .wdata_i (q_wdata),
      .pop_i   (q_pop),
      .rdata_o (q_rdata),
      .full_o  (q_full),
      .empty_o (q_empty),
      .count_o (q_count)
   );

   // Addresses of requests in flight; its occupancy is the outstanding count.
   riscv_fetch_fifo #(
      .QDEPTH (QDEPTH),
      .WIDTH  (32)
   ) u_addr_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (1'b0),
      .push_i  (req_fire),
      .wdata_i (fetch_pc_q),
      .pop_i   (rsp_eff),
      .rdata_o (a_rdata),
      .full_o  (a_full),
      .empty_o (a_empty),
      .count_o (outstanding)
   );

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_cnt_d = drop_cnt_q;
      ir_d       = ir_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         // Everything still in flight after this edge belongs to the old path.
         drop_cnt_d = outstanding - CntW'(rsp_eff);
         ir_d       = NopInsn;
         valid_d    = 1'b0;
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
         if (rsp_drop) drop_cnt_d = drop_cnt_q - CntW'(1);
         if (!stall) begin
            if (!q_empty) begin
               ir_d    = q_rdata.ir;
               pc_d    = q_rdata.pc;
               valid_d = 1'b1;
            end else if (bypass_take) begin
               ir_d    = imem_rsp_data;
               pc_d    = a_rdata;
               valid_d = 1'b1;
            end else begin
               ir_d    = NopInsn;
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         drop_cnt_q <= '0;
         ir_q       <= NopInsn;
         pc_q       <= '0;
         valid_q    <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_cnt_q <= drop_cnt_d;
         ir_q       <= ir_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
      end
   end

   assign ifid_ir    = ir_q;
   assign ifid_pc    = pc_q;
   assign ifid_valid = valid_q;

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
// Bench for riscv_ifetch_queue: directed vector table, corner-case sequences and a random run
// against a queue-based reference model.
module tb_riscv_ifetch_queue;
   import riscv_pkg::*;

   localparam logic [31:0] ResetPc = 32'h0000_0000;
   localparam int          Qd      = 4;
`ifdef FETCH_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, ifid_ir, ifid_pc;
   logic        redirect, stall, ifid_valid;

   riscv_ifetch_queue #(
      .RESET_PC (ResetPc),
      .QDEPTH   (Qd)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .ifid_ir        (ifid_ir),
      .ifid_pc        (ifid_pc),
      .ifid_valid     (ifid_valid)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Memory: in-order pending accepted addresses, IMemory[i] = i + 1.
   logic [31:0] mem_pend[$];
   int          rsp_pct = 100;
   bit          mem_hold = 1'b0;
   bit          force_stray = 1'b0;

   // Reference model state.
   logic [63:0] m_q[$];
   logic [31:0] m_out[$];
   int          m_drop;
   logic [31:0] m_fpc, m_ir, m_pc;
   bit          m_v, m_rv;
   bit          model_ok = 1'b0;

   logic        cap_rv;
   logic [31:0] cap_addr;

   typedef struct {
      bit          rst, st, rd;
      logic [31:0] rpc;
      bit          chk, ev;
      logic [31:0] epc, eir;
      bit          erv;
      logic [31:0] eaddr;
   } vec_t;
   vec_t tbl [18];

   function automatic vec_t mk(bit rst, bit st, bit rd, logic [31:0] rpc, bit chk, bit ev,
                               logic [31:0] epc, logic [31:0] eir, bit erv,
                               logic [31:0] eaddr);
      vec_t v;
      v.rst = rst; v.st = st; v.rd = rd; v.rpc = rpc; v.chk = chk; v.ev = ev;
      v.epc = epc; v.eir = eir; v.erv = erv; v.eaddr = eaddr;
      return v;
   endfunction

   task automatic model_edge(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                             input bit rdy, input bit rv, input bit rspv,
                             input logic [31:0] rdat);
      bit          acc, rsp, dropped, take;
      logic [31:0] rsp_pc;
      logic [63:0] ent;
      if (rst) begin
         m_q.delete();
         m_out.delete();
         m_drop = 0;
         m_fpc  = ResetPc;
         m_ir   = NopInsn;
         m_pc   = '0;
         m_v    = 1'b0;
         return;
      end
      acc     = rv && rdy;
      rsp     = rspv && (m_out.size() != 0);
      rsp_pc  = rsp ? m_out[0] : 32'h0;
      dropped = rsp && (rd || m_drop != 0);
      if (rsp) void'(m_out.pop_front());
      if (rd) begin
         m_q.delete();
         m_ir   = NopInsn;
         m_v    = 1'b0;
         m_fpc  = rpc;
         m_drop = m_out.size();
      end else begin
         if (acc) begin
            m_out.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
         end
         if (dropped) m_drop--;
         take = rsp && !dropped;
         if (!st) begin
            if (m_q.size() != 0) begin
               ent  = m_q.pop_front();
               m_ir = ent[63:32];
               m_pc = ent[31:0];
               m_v  = 1'b1;
            end else if (Bypass && take) begin
               m_ir = rdat;
               m_pc = rsp_pc;
               m_v  = 1'b1;
               take = 1'b0;
            end else begin
               m_ir = NopInsn;
               m_v  = 1'b0;
            end
         end
         if (take) m_q.push_back({rdat, rsp_pc});
      end
   endtask

   task automatic step(input bit rst, input bit st, input bit rd, input logic [31:0] rpc,
                       input bit rdy, input int row);
      @(negedge clock);
      reset          = rst;
      stall          = st;
      redirect       = rd;
      redirect_pc    = rpc;
      imem_req_ready = rdy;
      if (force_stray) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hdead_beef;
      end else if (!rst && mem_pend.size() != 0 && !mem_hold &&
                   int'($urandom_range(0, 99)) < rsp_pct) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = (mem_pend[0] >> 2) + 32'd1;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
      end
      #1;
      cap_rv   = imem_req_valid;
      cap_addr = imem_req_addr;
      m_rv     = !rst && !rd && (m_q.size() + m_out.size() < Qd);
      if (model_ok) begin
         check32("model_req_valid", {31'b0, imem_req_valid}, {31'b0, m_rv});
         if (m_rv) check32("model_req_addr", imem_req_addr, m_fpc);
         check32("model_ifid_valid", {31'b0, ifid_valid}, {31'b0, m_v});
         check32("model_ifid_ir", ifid_ir, m_ir);
         check32("model_ifid_pc", ifid_pc, m_pc);
      end
      if (row >= 0) begin
         check32($sformatf("tbl%0d_req_valid", row), {31'b0, imem_req_valid},
                 {31'b0, tbl[row].erv});
         if (tbl[row].erv) check32($sformatf("tbl%0d_req_addr", row), imem_req_addr,
                                   tbl[row].eaddr);
         if (tbl[row].chk) begin
            check32($sformatf("tbl%0d_ifid_valid", row), {31'b0, ifid_valid},
                    {31'b0, tbl[row].ev});
            check32($sformatf("tbl%0d_ifid_pc", row), ifid_pc, tbl[row].epc);
            check32($sformatf("tbl%0d_ifid_ir", row), ifid_ir, tbl[row].eir);
         end
      end
      @(posedge clock);
      if (rst) begin
         mem_pend.delete();
      end else begin
         if (imem_rsp_valid && !force_stray && mem_pend.size() != 0) void'(mem_pend.pop_front());
         if (cap_rv && rdy) mem_pend.push_back(cap_addr);
      end
      model_edge(rst, st, rd, rpc, rdy, m_rv, imem_rsp_valid, imem_rsp_data);
      if (rst) model_ok = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=still running expected=finished");
      $fatal(1);
   end

   initial begin
      bit r_rst, r_st, r_rd, r_rdy, found;

`ifdef FETCH_BYPASS_EN
      tbl[0]  = mk(1, 0, 0, 0,      0, 0, 0,      0,       0, 0);
      tbl[1]  = mk(1, 0, 0, 0,      1, 0, 0,      NopInsn, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,      1, 0, 0,      NopInsn, 1, 32'h0);
      tbl[3]  = mk(0, 0, 0, 0,      1, 0, 0,      NopInsn, 1, 32'h4);
      tbl[4]  = mk(0, 0, 0, 0,      1, 1, 32'h0,  32'h1,   1, 32'h8);
      tbl[5]  = mk(0, 0, 0, 0,      1, 1, 32'h4,  32'h2,   1, 32'hc);
      tbl[6]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   1, 32'h10);
      tbl[7]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   1, 32'h14);
      tbl[8]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   1, 32'h18);
      tbl[9]  = mk(0, 0, 0, 0,      1, 1, 32'h8,  32'h3,   0, 0);
      tbl[10] = mk(0, 0, 0, 0,      1, 1, 32'hc,  32'h4,   1, 32'h1c);
      tbl[11] = mk(0, 0, 0, 0,      1, 1, 32'h10, 32'h5,   1, 32'h20);
      tbl[12] = mk(0, 0, 0, 0,      1, 1, 32'h14, 32'h6,   1, 32'h24);
      tbl[13] = mk(0, 1, 1, 32'h100, 1, 1, 32'h18, 32'h7,  0, 0);
      tbl[14] = mk(0, 0, 0, 0,      1, 0, 32'h18, NopInsn, 1, 32'h100);
      tbl[15] = mk(0, 0, 0, 0,      1, 0, 32'h18, NopInsn, 1, 32'h104);
      tbl[16] = mk(0, 0, 0, 0,      1, 1, 32'h100, 32'h41, 1, 32'h108);
      tbl[17] = mk(0, 0, 0, 0,      1, 1, 32'h104, 32'h42, 1, 32'h10c);
`else
      tbl[0]  = mk(1, 0, 0, 0,      0, 0, 0,      0,       0, 0);
      tbl[1]  = mk(1, 0, 0, 0,      1, 0, 0,      NopInsn, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,      1, 0, 0,      NopInsn, 1, 32'h0);
      tbl[3]  = mk(0, 0, 0, 0,      1, 0, 0,      NopInsn, 1, 32'h4);
      tbl[4]  = mk(0, 0, 0, 0,      1, 0, 0,      NopInsn, 1, 32'h8);
      tbl[5]  = mk(0, 0, 0, 0,      1, 1, 32'h0,  32'h1,   1, 32'hc);
      tbl[6]  = mk(0, 0, 0, 0,      1, 1, 32'h4,  32'h2,   1, 32'h10);
      tbl[7]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   1, 32'h14);
      tbl[8]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   1, 32'h18);
      tbl[9]  = mk(0, 1, 0, 0,      1, 1, 32'h8,  32'h3,   0, 0);
      tbl[10] = mk(0, 0, 0, 0,      1, 1, 32'h8,  32'h3,   0, 0);
      tbl[11] = mk(0, 0, 0, 0,      1, 1, 32'hc,  32'h4,   1, 32'h1c);
      tbl[12] = mk(0, 0, 0, 0,      1, 1, 32'h10, 32'h5,   1, 32'h20);
      tbl[13] = mk(0, 1, 1, 32'h100, 1, 1, 32'h14, 32'h6,  0, 0);
      tbl[14] = mk(0, 0, 0, 0,      1, 0, 32'h14, NopInsn, 1, 32'h100);
      tbl[15] = mk(0, 0, 0, 0,      1, 0, 32'h14, NopInsn, 1, 32'h104);
      tbl[16] = mk(0, 0, 0, 0,      1, 0, 32'h14, NopInsn, 1, 32'h108);
      tbl[17] = mk(0, 0, 0, 0,      1, 1, 32'h100, 32'h41, 1, 32'h10c);
`endif

      reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

      // Reset, streaming, stall hold and redirect+stall+response in one cycle.
      for (int i = 0; i < 18; i++) step(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].rpc, 1'b1, i);

      // Redirect with two requests outstanding.
      mem_hold = 1'b1;
      for (int i = 0; i < 20 && mem_pend.size() < 2; i++) step(0, 0, 0, 0, 1, -1);
      check32("t3_outstanding", mem_pend.size(), 2);
      step(0, 0, 1, 32'h100, 1, -1);
      #1;
      check32("t3_nop_valid", {31'b0, ifid_valid}, 32'h0);
      check32("t3_nop_ir", ifid_ir, NopInsn);
      mem_hold = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step(0, 0, 0, 0, 1, -1);
         #1;
         found = ifid_valid;
      end
      check32("t3_valid_seen", {31'b0, found}, 32'h1);
      check32("t3_first_pc", ifid_pc, 32'h100);
      check32("t3_first_ir", ifid_ir, 32'h41);

      // Memory not ready for five cycles.
      for (int i = 0; i < 5; i++) begin
         logic [31:0] first_addr;
         step(0, 0, 0, 0, 0, -1);
         if (i == 0) first_addr = cap_addr;
         else check32("t4_addr_hold", cap_addr, first_addr);
         check32("t4_outstanding_le_qdepth", {31'b0, mem_pend.size() <= Qd}, 32'h1);
      end

      // Reset arriving right after a redirect that left three responses to drop.
      mem_hold = 1'b1;
      for (int i = 0; i < 20 && mem_pend.size() < 3; i++) step(0, 0, 0, 0, 1, -1);
      check32("t6_outstanding", mem_pend.size(), 3);
      step(0, 0, 1, 32'h300, 1, -1);
      step(1, 1, 1, 32'h400, 1, -1);
      #1;
      check32("t6_rst_valid", {31'b0, ifid_valid}, 32'h0);
      check32("t6_rst_ir", ifid_ir, NopInsn);
      check32("t6_rst_pc", ifid_pc, 32'h0);
      mem_hold = 1'b0;
      force_stray = 1'b1;
      step(0, 0, 0, 0, 1, -1);
      force_stray = 1'b0;
      check32("t6_first_req_valid", {31'b0, cap_rv}, 32'h1);
      check32("t6_first_req_addr", cap_addr, ResetPc);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, -1);

      // Random traffic against the reference model.
      rsp_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         r_rst = ($urandom_range(0, 999) < 3);
         r_st  = ($urandom_range(0, 99) < 20);
         r_rd  = ($urandom_range(0, 99) < 4);
         r_rdy = ($urandom_range(0, 99) < 75);
         step(r_rst, r_st, r_rd, $urandom & 32'h0000_fffc, r_rdy, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
